act_pool_pingpong: RTL

ACT_POOL_PINGPONG -- requirements
Module: act_pool_pingpong

---
 rtl/act_pool_pingpong_pkg.sv | 8 +
 rtl/act_pool_lane.sv | 28 ++
 rtl/act_pool_pingpong.sv | 106 ++++++++++
 3 files changed

// File: rtl/act_pool_pingpong_pkg.sv
// Shared constants and bank-state encoding for the activation/pool ping-pong buffer.
package acpo_pkg;
  localparam int LANES_D = 16;
  localparam int DW_D    = 8;
  localparam int DEPTH_D = 1024;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;
endpackage

// File: rtl/act_pool_lane.sv
// One lane: ReLU, then either pass-through or pairwise max with a held first beat.
module act_pool_lane import acpo_pkg::*; #(
  parameter int DATA_WIDTH = DW_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc,
  input  logic                         relu,
  input  logic                         pool,
  input  logic                         second,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);
  logic signed [DATA_WIDTH-1:0] r, hold;

  assign r = (relu && din[DATA_WIDTH-1]) ? '0 : din;

  // dout is loaded on every accepted beat; the top decides whether it is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      dout <= '0;
    end else if (acc) begin
      if (pool && !second) hold <= r;
      dout <= (pool && second && (hold > r)) ? hold : r;
    end
  end
endmodule

// File: rtl/act_pool_pingpong.sv
// Two-bank activation/pool frame buffer: fills one bank while the other is read out.
module act_pool_pingpong import acpo_pkg::*; #(
  parameter int LANES      = LANES_D,
  parameter int DATA_WIDTH = DW_D,
  parameter int DEPTH      = DEPTH_D,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(LANES),
  localparam int CW = AW + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_relu_en,
  input  logic                        cfg_pool_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        frame_ready,
  output logic [CW-1:0]               frame_len,
  input  logic                        rd_en,
  input  logic [AW+LW-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  input  logic                        rd_done,
  output logic                        ovf_err
);
  typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t         din, lane_out;
  vec_t         mem [2][DEPTH];
  bank_st_e     st [2];
  logic [CW-1:0] cnt [2];
  logic         wr_bank, rd_bank, wr_bank_q, wr_pend, wr_last_q, phase;
  logic         relu_q, pool_q, acc, first, relu_eff, pool_eff, release_b, wr_ok;

  assign din         = in_data;
  assign in_ready    = (st[wr_bank] != FULL);
  assign frame_ready = (st[rd_bank] == FULL);
  assign frame_len   = frame_ready ? cnt[rd_bank] : '0;
  assign acc         = in_valid && in_ready;
  assign first       = (st[wr_bank] == EMPTY);
  // Config is taken live on the opening beat, then frozen for the rest of the frame.
  assign relu_eff    = first ? cfg_relu_en : relu_q;
  assign pool_eff    = first ? cfg_pool_en : pool_q;
  assign release_b   = rd_done && frame_ready;
  assign wr_ok       = wr_pend && (cnt[wr_bank_q] != CW'(DEPTH));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_pool_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk(clk), .rst(rst), .acc(acc), .relu(relu_eff), .pool(pool_eff),
      .second(phase), .din(din[g]), .dout(lane_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_pend   <= 1'b0;
      wr_last_q <= 1'b0;
      phase     <= 1'b0;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      wr_pend   <= acc && (!pool_eff || phase || in_last);
      wr_last_q <= acc && in_last;
      if (acc) begin
        wr_bank_q <= wr_bank;
        phase     <= pool_eff && !in_last && !phase;
        if (first) begin
          relu_q <= cfg_relu_en;
          pool_q <= cfg_pool_en;
        end
        // Retarget at acceptance so the write cycle cannot admit a beat into the closing bank.
        if (in_last) wr_bank <= ~wr_bank;
      end
      if (release_b) rd_bank <= ~rd_bank;
      if (wr_pend) begin
        if (wr_ok) cnt[wr_bank_q] <= cnt[wr_bank_q] + CW'(1);
        else       ovf_err        <= 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        if (acc && first && (wr_bank == 1'(b))) st[b] <= FILLING;
        if (wr_last_q && (wr_bank_q == 1'(b)))  st[b] <= FULL;
        if (release_b && (rd_bank == 1'(b))) begin
          st[b]  <= EMPTY;
          cnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank_q][cnt[wr_bank_q][AW-1:0]] <= lane_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_bank][rd_addr[AW+LW-1:LW]][rd_addr[LW-1:0]];
  end
endmodule
